// File: rtl/control_unit_pkg.sv
// Shared constants and types for the 8-bit RISC control unit:
// opcodes, ALU and write-data select codes, FSM states, decode bundle.
package control_unit_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_MOV  = 4'h5;
    localparam logic [3:0] OP_LDI  = 4'h6;
    localparam logic [3:0] OP_BEQZ = 4'h7;
    localparam logic [3:0] OP_JMP  = 4'h8;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [2:0] ALU_ADD    = 3'd0;
    localparam logic [2:0] ALU_SUB    = 3'd1;
    localparam logic [2:0] ALU_AND    = 3'd2;
    localparam logic [2:0] ALU_OR     = 3'd3;
    localparam logic [2:0] ALU_PASS_B = 3'd4;

    localparam logic [1:0] WSEL_ALU  = 2'd0;
    localparam logic [1:0] WSEL_IMM  = 2'd1;
    localparam logic [1:0] WSEL_REG2 = 2'd2;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_FETCH,
        ST_DECODE,
        ST_FETCH_IMM,
        ST_EXEC,
        ST_WB,
        ST_HALT
    } state_e;

    typedef struct packed {
        logic [2:0] alu_op;
        logic [1:0] wdata_sel;
        logic       needs_imm;
        logic       writes_rf;
        logic       is_branch;
        logic       is_jmp;
        logic       is_halt;
    } dec_t;

    function automatic logic [3:0] opcode(input logic [7:0] ir);
        return ir[7:4];
    endfunction

endpackage

// File: rtl/control_unit_instr_decode.sv
// Combinational opcode decode of the instruction register.
// Illegal opcodes 9..E fall through to the all-zero (NOP) bundle.
module control_unit_instr_decode
    import control_unit_pkg::*;
(
    input  logic [7:0] ir_i,
    output dec_t       dec_o
);

    always_comb begin
        dec_o = '0;
        unique case (opcode(ir_i))
            OP_ADD: begin
                dec_o.alu_op    = ALU_ADD;
                dec_o.writes_rf = 1'b1;
            end
            OP_SUB: begin
                dec_o.alu_op    = ALU_SUB;
                dec_o.writes_rf = 1'b1;
            end
            OP_AND: begin
                dec_o.alu_op    = ALU_AND;
                dec_o.writes_rf = 1'b1;
            end
            OP_OR: begin
                dec_o.alu_op    = ALU_OR;
                dec_o.writes_rf = 1'b1;
            end
            OP_MOV: begin
                dec_o.alu_op    = ALU_PASS_B;
                dec_o.wdata_sel = WSEL_REG2;
                dec_o.writes_rf = 1'b1;
            end
            OP_LDI: begin
                dec_o.wdata_sel = WSEL_IMM;
                dec_o.needs_imm = 1'b1;
                dec_o.writes_rf = 1'b1;
            end
            OP_BEQZ: begin
                dec_o.alu_op    = ALU_PASS_B;
                dec_o.needs_imm = 1'b1;
                dec_o.is_branch = 1'b1;
            end
            OP_JMP: begin
                dec_o.needs_imm = 1'b1;
                dec_o.is_jmp    = 1'b1;
            end
            OP_HALT: dec_o.is_halt = 1'b1;
            default: dec_o = '0;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle control FSM: fetches instruction bytes, sequences the
// 4x8 register file and drives ALU op, write-data select and PC.
module control_unit
    import control_unit_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            instr_valid,
    input  logic [7:0]      instr,
    output logic            instr_ready,
    output logic [PC_W-1:0] pc,
    input  logic            alu_zero,
    output logic [2:0]      alu_op,
    output logic            rf_reset,
    output logic            rf_we,
    output logic [1:0]      reg1,
    output logic [1:0]      reg2,
    output logic [1:0]      wreg,
    output logic [1:0]      wdata_sel,
    output logic [7:0]      imm,
    output logic            halted
);

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [7:0]      ir_q, ir_d;
    logic [7:0]      imm_q, imm_d;
    logic            in_instr;
    dec_t            dec;

    control_unit_instr_decode u_instr_decode (
        .ir_i  (ir_q),
        .dec_o (dec)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_INIT;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            imm_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            imm_q   <= imm_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        imm_d       = imm_q;
        instr_ready = 1'b0;
        rf_reset    = 1'b0;
        rf_we       = 1'b0;
        halted      = 1'b0;
        in_instr    = 1'b0;
        unique case (state_q)
            ST_INIT: begin
                rf_reset = 1'b1;
                state_d  = ST_FETCH;
            end
            ST_FETCH: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    ir_d    = instr;
                    pc_d    = pc_q + PC_W'(1);
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                in_instr = 1'b1;
                if (dec.is_halt) begin
                    state_d = ST_HALT;
                end else if (dec.needs_imm) begin
                    state_d = ST_FETCH_IMM;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_FETCH_IMM: begin
                in_instr    = 1'b1;
                instr_ready = 1'b1;
                if (instr_valid) begin
                    imm_d   = instr;
                    pc_d    = pc_q + PC_W'(1);
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                in_instr = 1'b1;
                if (dec.is_jmp || (dec.is_branch && alu_zero)) begin
                    pc_d = PC_W'(imm_q);
                end
                state_d = dec.writes_rf ? ST_WB : ST_FETCH;
            end
            ST_WB: begin
                in_instr = 1'b1;
                rf_we    = 1'b1;
                state_d  = ST_FETCH;
            end
            ST_HALT: halted = 1'b1;
            default: state_d = ST_INIT;
        endcase
    end

    // Datapath selects are only meaningful while an instruction is in flight.
    always_comb begin
        reg1      = '0;
        reg2      = '0;
        wreg      = '0;
        alu_op    = '0;
        wdata_sel = '0;
        if (in_instr) begin
            reg1      = ir_q[3:2];
            reg2      = dec.is_branch ? ir_q[3:2] : ir_q[1:0];
            wreg      = ir_q[3:2];
            alu_op    = dec.alu_op;
            wdata_sel = dec.wdata_sel;
        end
    end

    assign pc  = pc_q;
    assign imm = imm_q;

endmodule
